// File: rtl/hub75_row_sr_rx.sv
// HUB75 panel-side row-address receiver: shifts serial address bits, latches them onto the
// row drivers on LE, and reports each latch as a clean one-hot row or a classified error.
module hub75_row_sr_rx #(
  parameter int unsigned N_ROWS     = 32,
  parameter int unsigned LOG_N_ROWS = $clog2(N_ROWS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  phy_sr_clk,
  input  logic                  phy_sr_data,
  input  logic                  phy_le,
  output logic [N_ROWS-1:0]     row_sel,
  output logic [LOG_N_ROWS-1:0] row_addr,
  output logic                  row_valid,
  output logic                  row_err,
  output logic [1:0]            err_code
);

  localparam logic [LOG_N_ROWS:0] CntFull = (LOG_N_ROWS+1)'(N_ROWS);
  localparam logic [LOG_N_ROWS:0] CntMax  = (LOG_N_ROWS+1)'(N_ROWS + 1);

  typedef enum logic [2:0] {StIdle, StShift, StLatch, StReport, StWait} state_e;

  state_e                state_q;
  logic                  sr_clk_r, sr_clk_rr, sr_data_r, le_r, le_rr;
  logic [N_ROWS-1:0]     sr_q;
  logic [N_ROWS-1:0]     row_sel_q;
  logic [LOG_N_ROWS:0]   bit_cnt_q;
  logic                  proto_err_q;
  logic [LOG_N_ROWS-1:0] row_addr_q;
  logic                  row_valid_q, row_err_q;
  logic [1:0]            err_code_q;

  logic                  sr_rise, shift_ev, bad_edge, latch_ev;
  logic [LOG_N_ROWS:0]   bit_cnt_inc;
  logic [LOG_N_ROWS:0]   ones;
  logic [LOG_N_ROWS-1:0] hot_idx;

  assign sr_rise     = sr_clk_r & ~sr_clk_rr;
  assign shift_ev    = sr_rise & ~le_r;
  assign bad_edge    = sr_rise & le_r;
  assign latch_ev    = le_r & ~le_rr;
  assign bit_cnt_inc = (bit_cnt_q == CntMax) ? CntMax : bit_cnt_q + 1'b1;

  // Population count and index of the highest set bit of the latched word.
  always_comb begin
    ones    = '0;
    hot_idx = '0;
    for (int i = 0; i < int'(N_ROWS); i++) begin
      if (row_sel_q[i]) begin
        ones    = ones + 1'b1;
        hot_idx = LOG_N_ROWS'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sr_clk_r    <= 1'b0;
      sr_clk_rr   <= 1'b0;
      sr_data_r   <= 1'b0;
      le_r        <= 1'b0;
      le_rr       <= 1'b0;
      sr_q        <= '0;
      row_sel_q   <= '0;
      bit_cnt_q   <= '0;
      proto_err_q <= 1'b0;
      row_addr_q  <= '0;
      row_valid_q <= 1'b0;
      row_err_q   <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      sr_clk_r    <= phy_sr_clk;
      sr_clk_rr   <= sr_clk_r;
      sr_data_r   <= phy_sr_data;
      le_r        <= phy_le;
      le_rr       <= le_r;
      row_valid_q <= 1'b0;
      row_err_q   <= 1'b0;
      err_code_q  <= 2'b00;

      if (latch_ev) row_sel_q <= sr_q;
      if (shift_ev && state_q != StWait) sr_q <= {sr_q[N_ROWS-2:0], sr_data_r};
      if (bad_edge || (shift_ev && state_q == StWait)) proto_err_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (latch_ev) begin
            state_q <= StLatch;
          end else if (shift_ev) begin
            state_q   <= StShift;
            bit_cnt_q <= bit_cnt_inc;
          end
        end
        StShift: begin
          if (latch_ev) state_q <= StLatch;
          else if (shift_ev) bit_cnt_q <= bit_cnt_inc;
        end
        StLatch: begin
          state_q <= StReport;
          if (bit_cnt_q != CntFull || proto_err_q) begin
            row_err_q  <= 1'b1;
            err_code_q <= 2'b01;
          end else if (ones == '0) begin
            row_err_q  <= 1'b1;
            err_code_q <= 2'b10;
          end else if (ones > (LOG_N_ROWS+1)'(1)) begin
            row_err_q  <= 1'b1;
            err_code_q <= 2'b11;
          end else begin
            row_valid_q <= 1'b1;
            row_addr_q  <= hot_idx;
          end
        end
        StReport: begin
          // A bad edge in this very cycle must survive the clear.
          bit_cnt_q   <= shift_ev ? (LOG_N_ROWS+1)'(1) : '0;
          proto_err_q <= bad_edge;
          if (le_r)          state_q <= StWait;
          else if (shift_ev) state_q <= StShift;
          else               state_q <= StIdle;
        end
        StWait: begin
          if (!le_r) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign row_sel   = row_sel_q;
  assign row_addr  = row_addr_q;
  assign row_valid = row_valid_q;
  assign row_err   = row_err_q;
  assign err_code  = err_code_q;

endmodule
